saratoga_irq_ctrl: RTL and testbench

Machine-level interrupt controller for the saratoga core. Synchronizes the standard (MSI/MTI/MEI) and platform (UART0, TIM0/1, GPIOA/B/C) interrupt lines and builds the mip image in interrupt_csr_t layout. Masks pending bits with mie and mstatus.MIE, selects the highest-priority interrupt, and runs a request/acknowledge handshake with the core trap unit. Sits between the peripherals and the CSR/trap logic.

---
 rtl/saratoga_irq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_saratoga_irq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/saratoga_irq_ctrl.sv
// saratoga_irq_ctrl: machine-level interrupt controller (sync, mip image, priority, trap handshake).
// Optional vectored trap PC output enabled by defining SARATOGA_IRQ_VECTORED_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no request; arbitrate when mstatus.MIE set and something pends
// ST_REQ  | trap_req_o high, code frozen until ack or withdrawal
// ST_HOLD | one quiet cycle after ack so the core's MIE clear lands
module saratoga_irq_ctrl #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EDGE_MASK   = 32'h03F0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msip_i,
    input  logic        mtip_i,
    input  logic        meip_i,
    input  logic [9:0]  plat_irq_i,
    input  logic [31:0] mie_i,
    input  logic        mstatus_mie_i,
    input  logic        mip_clr_i,
    input  logic [31:0] mip_clr_mask_i,
`ifdef SARATOGA_IRQ_VECTORED_EN
    input  logic [31:0] mtvec_i,
    output logic [31:0] trap_pc_o,
`endif
    output logic [31:0] mip_o,
    output logic        trap_req_o,
    output logic [4:0]  trap_code_o,
    input  logic        trap_ack_i,
    output logic        wake_o
);

    localparam logic [31:0] IMPL_MASK = 32'h03FF_0888;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] sync_d [SYNC_STAGES];
    logic [31:0] raw;
    logic [31:0] sync_out;
    logic [31:0] hist_q, hist_d;
    logic [31:0] mip_q, mip_d;
    logic [31:0] edge_set;
    logic [31:0] edge_clr;
    logic [31:0] pend;
    logic        wake_q, wake_d;
    logic        trap_req_q, trap_req_d;
    logic [4:0]  trap_code_q, trap_code_d;
    logic [4:0]  win_code;
    logic        win_valid;
    logic        ack_take;
    logic        withdraw;

    always_comb begin
        raw            = '0;
        raw[3]         = msip_i;
        raw[7]         = mtip_i;
        raw[11]        = meip_i;
        raw[25:16]     = plat_irq_i;
        sync_d[0]      = raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign ack_take = (state_q == ST_REQ) && trap_ack_i;

    // Edge bits: set beats any clear landing in the same cycle.
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        hist_d   = sync_out & EDGE_MASK;
        edge_set = sync_out & ~hist_q & EDGE_MASK;
        edge_clr = '0;
        if (mip_clr_i) begin
            edge_clr = mip_clr_mask_i;
        end
        if (ack_take) begin
            edge_clr[trap_code_q] = 1'b1;
        end
        mip_d  = ((sync_out & ~EDGE_MASK) | edge_set | (mip_q & EDGE_MASK & ~edge_clr))
                 & IMPL_MASK;
        pend   = mip_q & mie_i & IMPL_MASK;
        wake_d = |pend;
    end

    // Fixed priority: MEI, MSI, MTI, then platform bits ascending.
    always_comb begin
        win_valid = |pend;
        win_code  = '0;
        for (int n = 25; n >= 16; n--) begin
            if (pend[n]) begin
                win_code = 5'(n);
            end
        end
        if (pend[7]) begin
            win_code = 5'd7;
        end
        if (pend[3]) begin
            win_code = 5'd3;
        end
        if (pend[11]) begin
            win_code = 5'd11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign withdraw = !mstatus_mie_i || !pend[trap_code_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mstatus_mie_i && win_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (trap_ack_i) begin
                    state_d = ST_HOLD;
                end else if (withdraw) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        trap_req_d  = (state_d == ST_REQ);
        trap_code_d = trap_code_q;
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            trap_code_d = win_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            mip_q       <= '0;
            wake_q      <= 1'b0;
            trap_req_q  <= 1'b0;
            trap_code_q <= '0;
        end else begin
            hist_q      <= hist_d;
            mip_q       <= mip_d;
            wake_q      <= wake_d;
            trap_req_q  <= trap_req_d;
            trap_code_q <= trap_code_d;
        end
    end

`ifdef SARATOGA_IRQ_VECTORED_EN
    logic [31:0] trap_pc_q, trap_pc_d;
    logic [31:0] vec_base;

    always_comb begin
        vec_base  = {mtvec_i[31:2], 2'b00};
        trap_pc_d = trap_pc_q;
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            if (mtvec_i[1:0] == 2'b01) begin
                trap_pc_d = vec_base + {25'b0, win_code, 2'b00};
            end else begin
                trap_pc_d = vec_base;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_pc_q <= '0;
        end else begin
            trap_pc_q <= trap_pc_d;
        end
    end

    assign trap_pc_o = trap_pc_q;
`endif

    assign mip_o       = mip_q;
    assign trap_req_o  = trap_req_q;
    assign trap_code_o = trap_code_q;
    assign wake_o      = wake_q;

endmodule

// File: tb/tb_saratoga_irq_ctrl.sv
// Directed testbench for saratoga_irq_ctrl; define SARATOGA_IRQ_VECTORED_EN to cover trap_pc_o.
module tb_saratoga_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msip_i = 1'b0;
    logic        mtip_i = 1'b0;
    logic        meip_i = 1'b0;
    logic [9:0]  plat_irq_i = '0;
    logic [31:0] mie_i = '0;
    logic        mstatus_mie_i = 1'b0;
    logic        mip_clr_i = 1'b0;
    logic [31:0] mip_clr_mask_i = '0;
    logic [31:0] mip_o;
    logic        trap_req_o;
    logic [4:0]  trap_code_o;
    logic        trap_ack_i = 1'b0;
    logic        wake_o;
`ifdef SARATOGA_IRQ_VECTORED_EN
    logic [31:0] mtvec_i = '0;
    logic [31:0] trap_pc_o;
`endif

    int errors = 0;
    int checks = 0;

    saratoga_irq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .msip_i         (msip_i),
        .mtip_i         (mtip_i),
        .meip_i         (meip_i),
        .plat_irq_i     (plat_irq_i),
        .mie_i          (mie_i),
        .mstatus_mie_i  (mstatus_mie_i),
        .mip_clr_i      (mip_clr_i),
        .mip_clr_mask_i (mip_clr_mask_i),
`ifdef SARATOGA_IRQ_VECTORED_EN
        .mtvec_i        (mtvec_i),
        .trap_pc_o      (trap_pc_o),
`endif
        .mip_o          (mip_o),
        .trap_req_o     (trap_req_o),
        .trap_code_o    (trap_code_o),
        .trap_ack_i     (trap_ack_i),
        .wake_o         (wake_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        msip_i = 0; mtip_i = 0; meip_i = 0; plat_irq_i = '0;
        mie_i = '0; mstatus_mie_i = 0; mip_clr_i = 0; mip_clr_mask_i = '0;
        trap_ack_i = 0;
        rst_n = 0;
        tick(2);
        rst_n = 1;
    endtask

    task automatic test_reset();
        msip_i = 0; mtip_i = 0; meip_i = 0; plat_irq_i = '0;
        rst_n = 0;
        #2;
        checks++; if (mip_o !== 32'h0) begin errors++; $display("FAIL rst_mip got=%h exp=%h", mip_o, 32'h0); end
        checks++; if (trap_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", trap_req_o); end
        checks++; if (trap_code_o !== 5'd0) begin errors++; $display("FAIL rst_code got=%0d exp=0", trap_code_o); end
        checks++; if (wake_o !== 1'b0) begin errors++; $display("FAIL rst_wake got=%b exp=0", wake_o); end
        do_reset();
        tick(5);
        checks++; if (mip_o !== 32'h0 || trap_req_o !== 1'b0) begin errors++; $display("FAIL rst_idle mip=%h req=%b exp mip=0 req=0", mip_o, trap_req_o); end
    endtask

    task automatic test_level_trap();
        do_reset();
        mie_i = 32'h0000_0880; mstatus_mie_i = 1; mtip_i = 1;
        tick(2);
        checks++; if (mip_o[7] !== 1'b0) begin errors++; $display("FAIL mti_early got=%b exp=0", mip_o[7]); end
        tick(1);
        checks++; if (mip_o !== 32'h0000_0080 || trap_req_o !== 1'b0) begin errors++; $display("FAIL mti_lat mip=%h req=%b exp mip=00000080 req=0", mip_o, trap_req_o); end
        tick(1);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd7 || wake_o !== 1'b1) begin errors++; $display("FAIL mti_req req=%b code=%0d wake=%b exp 1/7/1", trap_req_o, trap_code_o, wake_o); end
        trap_ack_i = 1; tick(1); trap_ack_i = 0;
        checks++; if (trap_req_o !== 1'b0 || mip_o !== 32'h0000_0080) begin errors++; $display("FAIL mti_ack req=%b mip=%h exp req=0 mip=00000080", trap_req_o, mip_o); end
        tick(1);
        checks++; if (trap_req_o !== 1'b0) begin errors++; $display("FAIL mti_hold req=%b exp=0", trap_req_o); end
        tick(1);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd7) begin errors++; $display("FAIL mti_rereq req=%b code=%0d exp 1/7", trap_req_o, trap_code_o); end
    endtask

    task automatic test_priority();
        do_reset();
        mie_i = 32'h0000_0808; mstatus_mie_i = 1; meip_i = 1; msip_i = 1;
        tick(4);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd11) begin errors++; $display("FAIL pri_mei_msi req=%b code=%0d exp 1/11", trap_req_o, trap_code_o); end
        tick(3);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd11) begin errors++; $display("FAIL pri_hold11 req=%b code=%0d exp 1/11", trap_req_o, trap_code_o); end

        do_reset();
        mie_i = 32'h0000_0888; mstatus_mie_i = 1; mtip_i = 1;
        tick(4);
        checks++; if (trap_code_o !== 5'd7) begin errors++; $display("FAIL pri_mti code=%0d exp 7", trap_code_o); end
        meip_i = 1;
        tick(5);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd7) begin errors++; $display("FAIL pri_no_rearb req=%b code=%0d exp 1/7", trap_req_o, trap_code_o); end
        trap_ack_i = 1; tick(1); trap_ack_i = 0;
        tick(2);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd11) begin errors++; $display("FAIL pri_next11 req=%b code=%0d exp 1/11", trap_req_o, trap_code_o); end

        do_reset();
        mie_i = 32'h0001_0080; mstatus_mie_i = 1; mtip_i = 1; plat_irq_i = 10'h001;
        tick(4);
        checks++; if (trap_code_o !== 5'd7) begin errors++; $display("FAIL pri_mti_uart code=%0d exp 7", trap_code_o); end

        do_reset();
        mie_i = 32'h0202_0000; mstatus_mie_i = 1; plat_irq_i = 10'h202;
        tick(4);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd17) begin errors++; $display("FAIL pri_plat req=%b code=%0d exp 1/17", trap_req_o, trap_code_o); end
    endtask

    task automatic test_edge_wake();
        do_reset();
        mie_i = 32'h0010_0000; mstatus_mie_i = 0; plat_irq_i = 10'h010;
        tick(1); plat_irq_i = '0;
        tick(2);
        checks++; if (mip_o !== 32'h0010_0000) begin errors++; $display("FAIL gpio_set mip=%h exp=00100000", mip_o); end
        tick(4);
        checks++; if (mip_o !== 32'h0010_0000 || wake_o !== 1'b1 || trap_req_o !== 1'b0) begin errors++; $display("FAIL gpio_wake mip=%h wake=%b req=%b exp 00100000/1/0", mip_o, wake_o, trap_req_o); end
        mstatus_mie_i = 1;
        tick(1);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd20) begin errors++; $display("FAIL gpio_req req=%b code=%0d exp 1/20", trap_req_o, trap_code_o); end
        trap_ack_i = 1; tick(1); trap_ack_i = 0;
        checks++; if (mip_o !== 32'h0 || trap_req_o !== 1'b0) begin errors++; $display("FAIL gpio_ackclr mip=%h req=%b exp 0/0", mip_o, trap_req_o); end
        mstatus_mie_i = 0; plat_irq_i = 10'h010;
        tick(1); plat_irq_i = '0;
        tick(3);
        trap_ack_i = 1; tick(1); trap_ack_i = 0;
        checks++; if (mip_o[20] !== 1'b1 || trap_req_o !== 1'b0) begin errors++; $display("FAIL gpio_ack_idle mip20=%b req=%b exp 1/0", mip_o[20], trap_req_o); end
        mip_clr_i = 1; mip_clr_mask_i = 32'h0010_0000; tick(1); mip_clr_i = 0;
        checks++; if (mip_o !== 32'h0) begin errors++; $display("FAIL gpio_swclr mip=%h exp=0", mip_o); end
        tick(1);
        checks++; if (wake_o !== 1'b0) begin errors++; $display("FAIL gpio_wake_off wake=%b exp=0", wake_o); end
    endtask

    task automatic test_clear_race();
        do_reset();
        plat_irq_i = 10'h080; mtip_i = 1;
        tick(2);
        mip_clr_i = 1; mip_clr_mask_i = 32'hFFFF_FFFF;
        tick(1);
        mip_clr_i = 0;
        checks++; if (mip_o[23] !== 1'b1) begin errors++; $display("FAIL clr_race mip23=%b exp=1", mip_o[23]); end
        mip_clr_i = 1; tick(1); mip_clr_i = 0;
        checks++; if (mip_o !== 32'h0000_0080) begin errors++; $display("FAIL clr_level mip=%h exp=00000080", mip_o); end
    endtask

    task automatic test_withdraw();
        do_reset();
        mie_i = 32'h0001_0000; mstatus_mie_i = 1; plat_irq_i = 10'h001;
        tick(4);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd16) begin errors++; $display("FAIL wd_req req=%b code=%0d exp 1/16", trap_req_o, trap_code_o); end
        plat_irq_i = '0;
        tick(3);
        checks++; if (trap_req_o !== 1'b1) begin errors++; $display("FAIL wd_still req=%b exp=1", trap_req_o); end
        tick(1);
        checks++; if (trap_req_o !== 1'b0) begin errors++; $display("FAIL wd_drop req=%b exp=0", trap_req_o); end
        plat_irq_i = 10'h001;
        tick(4);
        checks++; if (trap_req_o !== 1'b1) begin errors++; $display("FAIL wd_rearm req=%b exp=1", trap_req_o); end
        mstatus_mie_i = 0; tick(1);
        checks++; if (trap_req_o !== 1'b0) begin errors++; $display("FAIL wd_mie req=%b exp=0", trap_req_o); end
        mstatus_mie_i = 1; tick(1);
        checks++; if (trap_req_o !== 1'b1) begin errors++; $display("FAIL wd_mie_back req=%b exp=1", trap_req_o); end
        trap_ack_i = 1; mstatus_mie_i = 0; tick(1);
        trap_ack_i = 0; mstatus_mie_i = 1; tick(1);
        checks++; if (trap_req_o !== 1'b0) begin errors++; $display("FAIL wd_ack_wins req=%b exp=0", trap_req_o); end
        tick(1);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd16) begin errors++; $display("FAIL wd_pre_rst req=%b code=%0d exp 1/16", trap_req_o, trap_code_o); end
        #2 rst_n = 0;
        #1;
        checks++; if (mip_o !== 32'h0 || trap_req_o !== 1'b0 || trap_code_o !== 5'd0 || wake_o !== 1'b0) begin errors++; $display("FAIL wd_async_rst mip=%h req=%b code=%0d wake=%b exp all 0", mip_o, trap_req_o, trap_code_o, wake_o); end
        tick(1);
        rst_n = 1;
    endtask

`ifdef SARATOGA_IRQ_VECTORED_EN
    task automatic test_vectored();
        do_reset();
        mtvec_i = 32'h0000_0101; mie_i = 32'h0008_0000; mstatus_mie_i = 1; plat_irq_i = 10'h008;
        tick(4);
        checks++; if (trap_req_o !== 1'b1 || trap_code_o !== 5'd19 || trap_pc_o !== 32'h0000_014C) begin errors++; $display("FAIL vec_pc req=%b code=%0d pc=%h exp 1/19/0000014c", trap_req_o, trap_code_o, trap_pc_o); end
        mtvec_i = 32'h0000_0100;
        tick(1);
        checks++; if (trap_pc_o !== 32'h0000_014C) begin errors++; $display("FAIL vec_hold pc=%h exp=0000014c", trap_pc_o); end
        trap_ack_i = 1; tick(1); trap_ack_i = 0;
        tick(2);
        checks++; if (trap_req_o !== 1'b1 || trap_pc_o !== 32'h0000_0100) begin errors++; $display("FAIL vec_direct req=%b pc=%h exp 1/00000100", trap_req_o, trap_pc_o); end
        rst_n = 0; #1;
        checks++; if (trap_pc_o !== 32'h0) begin errors++; $display("FAIL vec_rst pc=%h exp=0", trap_pc_o); end
        tick(1);
        rst_n = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_level_trap();
        test_priority();
        test_edge_wake();
        test_clear_race();
        test_withdraw();
`ifdef SARATOGA_IRQ_VECTORED_EN
        test_vectored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
